// File: rtl/hc_sr04_sensor_emu.sv
// hc_sr04_sensor_emu: responder side of the HC-SR04 trig/echo interface.
// It accepts a trig pulse that is at least TRIG_MIN cycles long, waits for the burst delay,
// and then holds echo high for dist_cm * CYC_PER_CM cycles. If dist_cm is 0 or above
// MAX_CM, echo is held high for TIMEOUT_CYC cycles instead.
// Latency: echo rises BURST_CYC+2 edges after the first edge that samples trig low at the pin.
// Backpressure: none; a trig that arrives during BURST/ECHO/HOLDOFF is ignored.
// Optional feature macro: HC_SR04_JITTER_EN. When it is defined, an LFSR adds
// -2^(JITTER_W-1)..2^(JITTER_W-1)-1 cycles to every in-range echo width.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   trig_i           asynchronous trigger from the ranging controller
//   dist_cm_i        emulated target distance in cm, sampled when trig is accepted
//   echo_o           echo pulse
//   busy_o           high whenever the FSM is not idle
//   done_o           1-cycle pulse on the first cycle that echo is low again
//   short_trig_o     1-cycle pulse when a trig shorter than TRIG_MIN is rejected
//   out_of_range_o   latched flag: the last accepted distance was 0 or above MAX_CM
module hc_sr04_sensor_emu #(
  parameter int unsigned DIST_W      = 12,
  parameter int unsigned TRIG_MIN    = 1000,
  parameter int unsigned BURST_CYC   = 20000,
  parameter int unsigned CYC_PER_CM  = 5882,
  parameter int unsigned MAX_CM      = 400,
  parameter int unsigned TIMEOUT_CYC = 3800000,
  parameter int unsigned HOLDOFF_CYC = 1000000
`ifdef HC_SR04_JITTER_EN
  , parameter int unsigned JITTER_W  = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_i,
  input  logic [DIST_W-1:0] dist_cm_i,
  output logic              echo_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              short_trig_o,
  output logic              out_of_range_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HI,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  state_t      state_q;
  logic        sync1_q, sync2_q, trig_prev_q;
  logic [31:0] tcnt_q;
  logic [31:0] cnt_q;
  logic [31:0] len_q;
  logic        echo_q, busy_q, done_q, short_q, oor_q;

  logic        trig_s;
  logic        trig_rise;
  logic        in_range;
  logic [31:0] base_len;
  logic [31:0] len_d;

  assign trig_s    = sync2_q;
  // A level that is already high when IDLE is entered does not count as an edge.
  assign trig_rise = trig_s & ~trig_prev_q;
  assign in_range  = (dist_cm_i != '0) && (32'(dist_cm_i) <= MAX_CM);
  assign base_len  = 32'(dist_cm_i) * 32'(CYC_PER_CM);

`ifdef HC_SR04_JITTER_EN
  localparam int unsigned JIT_OFS = 1 << (JITTER_W - 1);

  logic [15:0] lfsr_q;

  // This is a Galois LFSR for x^16+x^14+x^13+x^11+1. It shifts right and
  // uses the tap mask 16'hB400.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign len_d = in_range ? (base_len + 32'(lfsr_q[JITTER_W-1:0]) - 32'(JIT_OFS))
                          : 32'(TIMEOUT_CYC);
`else
  assign len_d = in_range ? base_len : 32'(TIMEOUT_CYC);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      trig_prev_q <= 1'b0;
      tcnt_q      <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      echo_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      oor_q       <= 1'b0;
    end else begin
      sync1_q     <= trig_i;
      sync2_q     <= sync1_q;
      trig_prev_q <= sync2_q;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (trig_rise) begin
            state_q <= S_TRIG_HI;
            tcnt_q  <= 32'd1;
            busy_q  <= 1'b1;
          end
        end
        S_TRIG_HI: begin
          if (trig_s) begin
            if (tcnt_q < TRIG_MIN) tcnt_q <= tcnt_q + 32'd1;
          end else if (tcnt_q >= TRIG_MIN) begin
            // The trig is accepted here. The echo length is frozen now, so later
            // changes on dist_cm_i do not affect this measurement.
            state_q <= S_BURST;
            cnt_q   <= 32'(BURST_CYC - 1);
            len_q   <= len_d;
            oor_q   <= ~in_range;
          end else begin
            state_q <= S_IDLE;
            short_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_BURST: begin
          if (cnt_q == '0) begin
            state_q <= S_ECHO;
            echo_q  <= 1'b1;
            cnt_q   <= len_q - 32'd1;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_ECHO: begin
          if (cnt_q == '0) begin
            state_q <= S_HOLDOFF;
            echo_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= 32'(HOLDOFF_CYC - 1);
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_HOLDOFF: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          echo_q  <= 1'b0;
        end
      endcase
    end
  end

  assign echo_o         = echo_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign short_trig_o   = short_q;
  assign out_of_range_o = oor_q;

endmodule

// File: tb/tb_hc_sr04_sensor_emu.sv
module tb_hc_sr04_sensor_emu;

  localparam int DIST_W      = 12;
  localparam int TRIG_MIN    = 8;
  localparam int BURST_CYC   = 20;
  localparam int CYC_PER_CM  = 5;
  localparam int MAX_CM      = 30;
  localparam int TIMEOUT_CYC = 200;
  localparam int HOLDOFF_CYC = 30;
`ifdef HC_SR04_JITTER_EN
  localparam int DMIN = 2;
`else
  localparam int DMIN = 1;
`endif

  logic              clk;
  logic              rst;
  logic              trig_i;
  logic [DIST_W-1:0] dist_cm_i;
  logic              echo_o, busy_o, done_o, short_trig_o, out_of_range_o;

  hc_sr04_sensor_emu #(
    .DIST_W(DIST_W), .TRIG_MIN(TRIG_MIN), .BURST_CYC(BURST_CYC), .CYC_PER_CM(CYC_PER_CM),
    .MAX_CM(MAX_CM), .TIMEOUT_CYC(TIMEOUT_CYC), .HOLDOFF_CYC(HOLDOFF_CYC)
  ) dut (
    .clk(clk), .rst(rst), .trig_i(trig_i), .dist_cm_i(dist_cm_i),
    .echo_o(echo_o), .busy_o(busy_o), .done_o(done_o),
    .short_trig_o(short_trig_o), .out_of_range_o(out_of_range_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic is_short;
    int   width;
    logic oor;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   jmin   = 1000;
  int   jmax   = -1000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string nm, input int act, input int req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // This is the reference model. Trigs shorter than TRIG_MIN are rejected.
  // Otherwise the echo width is distance times CYC_PER_CM, or the timeout
  // width when the distance is out of range.
  function automatic exp_t model(input int n, input int d);
    exp_t e;
    e.is_short = (n < TRIG_MIN);
    if (d == 0 || d > MAX_CM) begin
      e.width = TIMEOUT_CYC;
      e.oor   = 1'b1;
    end else begin
      e.width = d * CYC_PER_CM;
      e.oor   = 1'b0;
    end
    return e;
  endfunction

  // The monitor runs on the falling edge. At this point cyc equals the index of
  // the last rising edge. A trig level seen here is sampled at edge cyc+1.
  bit   pt = 0, pe = 0, pb = 0, oor_rise = 0;
  int   last_rise = 0, last_fall = 0, rise_cyc = 0, exp_busy_fall = 0;

  always @(negedge clk) begin
    exp_t e;
    int   w;
    if (trig_i && !pt) last_rise = cyc + 1;
    if (!trig_i && pt) last_fall = cyc + 1;
    pt = trig_i;
    if (rst) begin
      pe = 0;
      pb = 0;
    end else begin
      if (busy_o && !pb)
        check(cyc == last_rise + 2, "busy_rise_delay", cyc - last_rise, 2);
      if (echo_o && !pe) begin
        check(cyc == last_fall + BURST_CYC + 2, "echo_rise_delay", cyc - last_fall, BURST_CYC + 2);
        rise_cyc = cyc;
        oor_rise = out_of_range_o;
      end
      if (done_o || (pe && !echo_o))
        check(done_o == (pe && !echo_o), "done_pulse", int'(done_o), int'(pe && !echo_o));
      if (pe && !echo_o) begin
        w = cyc - rise_cyc;
        exp_busy_fall = cyc + HOLDOFF_CYC;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_echo", w, 0);
        end else begin
          e = exp_q.pop_front();
          check(!e.is_short, "event_kind_echo", 0, int'(e.is_short));
          check(oor_rise == e.oor, "out_of_range", int'(oor_rise), int'(e.oor));
`ifdef HC_SR04_JITTER_EN
          if (e.oor) begin
            check(w == e.width, "echo_width", w, e.width);
          end else begin
            check(w - e.width >= -8 && w - e.width <= 7, "echo_width_jitter", w, e.width);
            if (w - e.width < jmin) jmin = w - e.width;
            if (w - e.width > jmax) jmax = w - e.width;
          end
`else
          check(w == e.width, "echo_width", w, e.width);
`endif
        end
      end
      if (short_trig_o) begin
        exp_busy_fall = cyc;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_short_trig", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check(e.is_short, "event_kind_short", 1, int'(e.is_short));
          check(cyc == last_fall + 2, "short_trig_delay", cyc - last_fall, 2);
        end
      end
      if (!busy_o && pb)
        check(cyc == exp_busy_fall, "busy_fall", cyc, exp_busy_fall);
      pe = echo_o;
      pb = busy_o;
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0:       return echo_o;
      1:       return !busy_o;
      default: return done_o;
    endcase
  endfunction

  // This waits until sel is true, with a bounded cycle budget. sel 0 waits for echo high,
  // sel 1 waits for busy low, and sel 2 waits for done high.
  task automatic wait_for(input int sel, input string nm);
    int k = 0;
    while (!sig(sel) && k < 2000) begin
      tick(1);
      k++;
    end
    check(sig(sel), nm, int'(sig(sel)), 1);
  endtask

  task automatic pulse(input int n);
    trig_i = 1'b1;
    tick(n);
    trig_i = 1'b0;
  endtask

  task automatic run(input int n, input int d);
    int r;
    exp_q.push_back(model(n, d));
    dist_cm_i = d[DIST_W-1:0];
    pulse(n);
    tick(4);
    r = $urandom;
    dist_cm_i = r[DIST_W-1:0];
    wait_for(1, "wait_idle");
    tick($urandom_range(1, 4));
  endtask

  initial begin
    int n, d, r;
    rst = 1'b1; trig_i = 1'b0; dist_cm_i = '0;
    tick(4);
    check(echo_o == 0, "reset_echo", int'(echo_o), 0);
    check(busy_o == 0, "reset_busy", int'(busy_o), 0);
    check(done_o == 0, "reset_done", int'(done_o), 0);
    check(short_trig_o == 0, "reset_short", int'(short_trig_o), 0);
    check(out_of_range_o == 0, "reset_oor", int'(out_of_range_o), 0);
    rst = 1'b0;
    tick(3);

    // Directed cases: minimum accepted trig, short trigs, and the range boundaries.
    run(TRIG_MIN, 10);
    run(TRIG_MIN - 1, 10);
    run(1, 10);
    run(TRIG_MIN, 10);
    run(TRIG_MIN, 0);
    run(TRIG_MIN, MAX_CM + 1);
    run(TRIG_MIN, MAX_CM);
    run(TRIG_MIN + 20, 4095);

    // This case changes the distance during BURST and pulses trig during ECHO and HOLDOFF.
    exp_q.push_back(model(TRIG_MIN, 10));
    dist_cm_i = 12'd10;
    pulse(TRIG_MIN);
    tick(5);
    dist_cm_i = 12'd30;
    wait_for(0, "t4_echo_high");
    tick(3);
    pulse(TRIG_MIN + 1);
    wait_for(2, "t4_done");
    tick(2);
    pulse(TRIG_MIN + 1);
    wait_for(1, "t4_idle");
    tick(3);

    // This case asserts reset in the middle of ECHO.
    dist_cm_i = 12'd20;
    pulse(TRIG_MIN);
    wait_for(0, "t5_echo_high");
    tick(5);
    rst = 1'b1;
    tick(1);
    check(echo_o == 0, "rst_mid_echo_echo", int'(echo_o), 0);
    check(busy_o == 0, "rst_mid_echo_busy", int'(busy_o), 0);
    check(out_of_range_o == 0, "rst_mid_echo_oor", int'(out_of_range_o), 0);
    tick(1);
    rst = 1'b0;
    tick(3);

    // This case holds trig high across the HOLDOFF exit, so it must not be accepted.
    exp_q.push_back(model(TRIG_MIN, 10));
    dist_cm_i = 12'd10;
    pulse(TRIG_MIN);
    wait_for(0, "t5_held_echo_high");
    trig_i = 1'b1;
    wait_for(1, "t5_held_idle");
    tick(10);
    check(busy_o == 0, "held_trig_ignored_busy", int'(busy_o), 0);
    check(echo_o == 0, "held_trig_ignored_echo", int'(echo_o), 0);
    trig_i = 1'b0;
    tick(3);
    run(TRIG_MIN, 7);

    // Randomized runs.
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(1, TRIG_MIN + 6);
      r = $urandom_range(0, 5);
      if (r == 0)      d = 0;
      else if (r == 1) d = $urandom_range(MAX_CM + 1, 4095);
      else             d = $urandom_range(DMIN, MAX_CM);
      run(n, d);
    end

`ifdef HC_SR04_JITTER_EN
    for (int i = 0; i < 64; i++) run(TRIG_MIN, 10);
    check(jmax != jmin, "jitter_distinct", jmax - jmin, 1);
`endif

    tick(5);
    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got %0d cycles, expected completion sooner", cyc);
    $fatal(1, "watchdog");
  end

endmodule
